// File: rtl/stage_mem_access_pkg.sv
// Shared constants for the MEM stage: operation codes, FSM encodings and
// big-endian byte-lane masks.
package stage_mem_access_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Lane bit 3 carries bits 31:24, i.e. byte offset 0.
    localparam logic [3:0] BSEL_BYTE0   = 4'b1000;
    localparam logic [3:0] BSEL_HALF_HI = 4'b1100;
    localparam logic [3:0] BSEL_HALF_LO = 4'b0011;
    localparam logic [3:0] BSEL_WORD    = 4'b1111;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

endpackage

// File: rtl/stage_mem_access_load_store_align.sv
// Combinational lane steering: byte select, store replication, load
// extraction with sign/zero extension, and the alignment check.
module load_store_align
    import stage_mem_access_pkg::*;
(
    input  logic [3:0]  operation,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  byte_select,
    output logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic        sign_ext;

    always_comb begin
        case (byte_offset)
            2'd0:    lane_byte = read_data[31:24];
            2'd1:    lane_byte = read_data[23:16];
            2'd2:    lane_byte = read_data[15:8];
            default: lane_byte = read_data[7:0];
        endcase
        lane_half = byte_offset[1] ? read_data[15:0] : read_data[31:16];
        sign_ext  = (operation == OP_LB) || (operation == OP_LH);

        byte_select = BSEL_WORD;
        write_data  = store_data;
        load_data   = read_data;
        misaligned  = 1'b0;

        case (operation)
            OP_LB, OP_LBU, OP_SB: begin
                byte_select = BSEL_BYTE0 >> byte_offset;
                write_data  = {4{store_data[7:0]}};
                load_data   = {{24{sign_ext & lane_byte[7]}}, lane_byte};
            end
            OP_LH, OP_LHU, OP_SH: begin
                byte_select = byte_offset[1] ? BSEL_HALF_LO : BSEL_HALF_HI;
                write_data  = {2{store_data[15:0]}};
                load_data   = {{16{sign_ext & lane_half[15]}}, lane_half};
                misaligned  = byte_offset[0];
            end
            OP_LW, OP_SW: begin
                misaligned = |byte_offset;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_mem_access.sv
// MEM pipeline stage: runs one data-memory bus transaction per load/store,
// stalling the pipeline until acknowledge or timeout, then hands off to WB.
//
// state | meaning
// IDLE  | no transaction; passthrough, or launch bus cycle for aligned access
// BUS   | bus_request high, waiting for acknowledge or timeout
// DONE  | transaction over; writeback presented, bus_error pulsed on timeout
module stage_mem_access
    import stage_mem_access_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_register_write_enable,
    input  logic [4:0]  mem_register_write_address,
    input  logic [31:0] mem_register_write_data,
    input  logic [3:0]  mem_access_operation,
    input  logic [31:0] mem_access_address,
    input  logic [31:0] mem_store_data,
    output logic        wb_register_write_enable,
    output logic [4:0]  wb_register_write_address,
    output logic [31:0] wb_register_write_data,
    output logic        stall_request,
    output logic        address_error,
    output logic        bus_error,
    output logic        bus_request,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [3:0]  bus_byte_select,
    output logic [31:0] bus_write_data,
    input  logic [31:0] bus_read_data,
    input  logic        bus_acknowledge
);

    localparam int CNT_W = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [31:0]      result_q, result_d;
    logic             err_q, err_d;
    logic             bus_request_q, bus_request_d;
    logic             bus_write_q, bus_write_d;
    logic [31:0]      bus_address_q, bus_address_d;
    logic [3:0]       bus_byte_select_q, bus_byte_select_d;
    logic [31:0]      bus_write_data_q, bus_write_data_d;

    logic        is_load, is_store;
    logic [3:0]  lane_select;
    logic [31:0] lane_write_data, lane_load_data;
    logic        misaligned;

    assign is_load  = op_is_load(mem_access_operation);
    assign is_store = op_is_store(mem_access_operation);

    // EX/MEM is frozen while stalled, so the live inputs still describe the
    // in-flight access during BUS and DONE.
    load_store_align u_align (
        .operation   (mem_access_operation),
        .byte_offset (mem_access_address[1:0]),
        .store_data  (mem_store_data),
        .read_data   (bus_read_data),
        .byte_select (lane_select),
        .write_data  (lane_write_data),
        .load_data   (lane_load_data),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_d           = state_q;
        counter_d         = counter_q;
        result_d          = result_q;
        err_d             = err_q;
        bus_request_d     = bus_request_q;
        bus_write_d       = bus_write_q;
        bus_address_d     = bus_address_q;
        bus_byte_select_d = bus_byte_select_q;
        bus_write_data_d  = bus_write_data_q;

        stall_request             = 1'b0;
        address_error             = 1'b0;
        bus_error                 = 1'b0;
        wb_register_write_enable  = mem_register_write_enable;
        wb_register_write_address = mem_register_write_address;
        wb_register_write_data    = mem_register_write_data;

        case (state_q)
            ST_IDLE: begin
                if (is_load || is_store) begin
                    if (misaligned) begin
                        address_error            = 1'b1;
                        wb_register_write_enable = 1'b0;
                    end else begin
                        stall_request            = 1'b1;
                        wb_register_write_enable = 1'b0;
                        bus_request_d            = 1'b1;
                        bus_write_d              = is_store;
                        bus_address_d            = {mem_access_address[31:2], 2'b00};
                        bus_byte_select_d        = lane_select;
                        bus_write_data_d         = lane_write_data;
                        counter_d                = '0;
                        err_d                    = 1'b0;
                        state_d                  = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                stall_request            = 1'b1;
                wb_register_write_enable = 1'b0;
                counter_d                = counter_q + 1'b1;
                if (bus_acknowledge) begin
                    bus_request_d = 1'b0;
                    if (is_load) result_d = lane_load_data;
                    state_d = ST_DONE;
                end else if ((BUS_TIMEOUT != 0) && (counter_q == CNT_LAST)) begin
                    bus_request_d = 1'b0;
                    err_d         = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                bus_error                = err_q;
                wb_register_write_enable = mem_register_write_enable & ~err_q;
                if (is_load) wb_register_write_data = result_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            counter_q         <= '0;
            result_q          <= '0;
            err_q             <= 1'b0;
            bus_request_q     <= 1'b0;
            bus_write_q       <= 1'b0;
            bus_address_q     <= '0;
            bus_byte_select_q <= '0;
            bus_write_data_q  <= '0;
        end else begin
            state_q           <= state_d;
            counter_q         <= counter_d;
            result_q          <= result_d;
            err_q             <= err_d;
            bus_request_q     <= bus_request_d;
            bus_write_q       <= bus_write_d;
            bus_address_q     <= bus_address_d;
            bus_byte_select_q <= bus_byte_select_d;
            bus_write_data_q  <= bus_write_data_d;
        end
    end

    assign bus_request     = bus_request_q;
    assign bus_write       = bus_write_q;
    assign bus_address     = bus_address_q;
    assign bus_byte_select = bus_byte_select_q;
    assign bus_write_data  = bus_write_data_q;

endmodule

// File: tb/tb_stage_mem_access.sv
// Self-checking bench for stage_mem_access against a byte-level reference
// model of lane selection, replication and load extension.
module tb_stage_mem_access;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_register_write_enable;
    logic [4:0]  mem_register_write_address;
    logic [31:0] mem_register_write_data;
    logic [3:0]  mem_access_operation;
    logic [31:0] mem_access_address;
    logic [31:0] mem_store_data;
    logic        wb_register_write_enable;
    logic [4:0]  wb_register_write_address;
    logic [31:0] wb_register_write_data;
    logic        stall_request;
    logic        address_error;
    logic        bus_error;
    logic        bus_request;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_select;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_acknowledge;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int TIMEOUT = 4;

    always #5 clock = ~clock;

    stage_mem_access #(.BUS_TIMEOUT(TIMEOUT)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .mem_register_write_enable  (mem_register_write_enable),
        .mem_register_write_address (mem_register_write_address),
        .mem_register_write_data    (mem_register_write_data),
        .mem_access_operation       (mem_access_operation),
        .mem_access_address         (mem_access_address),
        .mem_store_data             (mem_store_data),
        .wb_register_write_enable   (wb_register_write_enable),
        .wb_register_write_address  (wb_register_write_address),
        .wb_register_write_data     (wb_register_write_data),
        .stall_request              (stall_request),
        .address_error              (address_error),
        .bus_error                  (bus_error),
        .bus_request                (bus_request),
        .bus_write                  (bus_write),
        .bus_address                (bus_address),
        .bus_byte_select            (bus_byte_select),
        .bus_write_data             (bus_write_data),
        .bus_read_data              (bus_read_data),
        .bus_acknowledge            (bus_acknowledge)
    );

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic logic [3:0] exp_bsel(input logic [3:0] op, input logic [31:0] addr);
        int s = op_size(op);
        int o = int'(addr[1:0]);
        logic [3:0] m = 4'b0000;
        for (int k = o; k < o + s; k++) m[3-k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] sd);
        int s = op_size(op);
        logic [63:0] mask = (64'd1 << (8*s)) - 64'd1;
        logic [63:0] acc = 64'd0;
        for (int i = 0; i < 4 / s; i++) acc = (acc << (8*s)) | ({32'd0, sd} & mask);
        return acc[31:0];
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int s = op_size(op);
        int o = int'(addr[1:0]);
        logic [63:0] mask = (64'd1 << (8*s)) - 64'd1;
        logic [63:0] v = ({32'd0, rd} >> (8*(4 - o - s))) & mask;
        if ((op == 4'd1 || op == 4'd3) && v[8*s-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive_none();
        mem_access_operation       = 4'd0;
        mem_access_address         = $urandom;
        mem_store_data             = $urandom;
        mem_register_write_enable  = 1'b1;
        mem_register_write_address = 5'($urandom);
        mem_register_write_data    = $urandom;
        bus_acknowledge            = 1'b0;
        bus_read_data              = $urandom;
    endtask

    // Entered and left just after a rising edge. ack_delay<0 means never ack.
    task automatic access(input string name, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rd, input logic we,
                          input logic [4:0] wa, input logic [31:0] wd, input int ack_delay);
        int  s      = op_size(op);
        bit  ld     = op_load(op);
        bit  mis    = (s != 0) && ((int'(addr[1:0]) % s) != 0);
        bit  acked  = (ack_delay >= 0) && (ack_delay < TIMEOUT);
        int  n_bus  = acked ? ack_delay + 1 : TIMEOUT;
        int  stalls = 0;
        int  reqs   = 0;
        mem_access_operation       = op;
        mem_access_address         = addr;
        mem_store_data             = sd;
        mem_register_write_enable  = we;
        mem_register_write_address = wa;
        mem_register_write_data    = wd;
        bus_acknowledge            = 1'b0;
        bus_read_data              = $urandom;
        @(negedge clock);
        if (s == 0) begin
            n_tests++;
            if ({stall_request, address_error, bus_request, wb_register_write_enable,
                 wb_register_write_address, wb_register_write_data} !== {3'b000, we, wa, wd}) begin
                n_fail++;
                $display("FAIL %s passthrough: got stall=%b aerr=%b req=%b en=%b wa=%0d wd=%h want 000 en=%b wa=%0d wd=%h",
                         name, stall_request, address_error, bus_request, wb_register_write_enable,
                         wb_register_write_address, wb_register_write_data, we, wa, wd);
            end
            @(posedge clock); #1;
            return;
        end
        if (mis) begin
            n_tests++;
            if ({address_error, stall_request, wb_register_write_enable, bus_request} !== 4'b1000) begin
                n_fail++;
                $display("FAIL %s misaligned: got aerr/stall/en/req=%b want 1000", name,
                         {address_error, stall_request, wb_register_write_enable, bus_request});
            end
            @(posedge clock); #1;
            drive_none();
            @(negedge clock);
            n_tests++;
            if ({bus_request, address_error} !== 2'b00) begin
                n_fail++;
                $display("FAIL %s misaligned_nobus: got req/aerr=%b want 00", name, {bus_request, address_error});
            end
            @(posedge clock); #1;
            return;
        end
        n_tests++;
        if ({stall_request, wb_register_write_enable, address_error, bus_request} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s launch: got stall/en/aerr/req=%b want 1000", name,
                     {stall_request, wb_register_write_enable, address_error, bus_request});
        end
        stalls += int'(stall_request);
        for (int i = 0; i < n_bus; i++) begin
            @(posedge clock); #1;
            bus_acknowledge = (i == ack_delay);
            bus_read_data   = (i == ack_delay) ? rd : $urandom;
            @(negedge clock);
            stalls += int'(stall_request);
            reqs   += int'(bus_request);
            n_tests++;
            if ({bus_request, stall_request, wb_register_write_enable} !== 3'b110) begin
                n_fail++;
                $display("FAIL %s bus_cycle%0d: got req/stall/en=%b want 110", name, i,
                         {bus_request, stall_request, wb_register_write_enable});
            end
            if (i == 0) begin
                n_tests++;
                if ({bus_write, bus_address, bus_byte_select} !==
                    {~ld, addr[31:2], 2'b00, exp_bsel(op, addr)}) begin
                    n_fail++;
                    $display("FAIL %s bus_fields: got wr=%b addr=%h bsel=%b want wr=%b addr=%h bsel=%b",
                             name, bus_write, bus_address, bus_byte_select, ~ld,
                             {addr[31:2], 2'b00}, exp_bsel(op, addr));
                end
                if (!ld) begin
                    n_tests++;
                    if (bus_write_data !== exp_wdata(op, sd)) begin
                        n_fail++;
                        $display("FAIL %s write_data: got %h want %h", name, bus_write_data, exp_wdata(op, sd));
                    end
                end
            end
        end
        @(posedge clock); #1;
        bus_acknowledge = 1'b0;
        bus_read_data   = $urandom;
        @(negedge clock);
        n_tests++;
        if ({stall_request, bus_request, address_error, bus_error, wb_register_write_enable,
             wb_register_write_address} !== {4'b0000 | {3'b000, ~acked}, we & acked, wa}) begin
            n_fail++;
            $display("FAIL %s done: got stall/req/aerr/berr=%b en=%b wa=%0d want berr=%b en=%b wa=%0d",
                     name, {stall_request, bus_request, address_error, bus_error},
                     wb_register_write_enable, wb_register_write_address, ~acked, we & acked, wa);
        end
        if (acked) begin
            n_tests++;
            if (wb_register_write_data !== (ld ? exp_load(op, addr, rd) : wd)) begin
                n_fail++;
                $display("FAIL %s wb_data: got %h want %h", name, wb_register_write_data,
                         ld ? exp_load(op, addr, rd) : wd);
            end
        end
        n_tests++;
        if (stalls != 1 + n_bus || reqs != n_bus) begin
            n_fail++;
            $display("FAIL %s stall_count: got stall=%0d req=%0d want stall=%0d req=%0d",
                     name, stalls, reqs, 1 + n_bus, n_bus);
        end
        @(posedge clock); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive_none();
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_tests++;
        if ({bus_request, bus_write, bus_address, bus_byte_select, bus_write_data,
             stall_request, address_error, bus_error} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b wr=%b addr=%h bsel=%b wd=%h stall=%b aerr=%b berr=%b want all 0",
                     bus_request, bus_write, bus_address, bus_byte_select, bus_write_data,
                     stall_request, address_error, bus_error);
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        access("lw_0x100",  4'd5, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 5'd3, 32'h1234, 0);
        access("lb_0x103",  4'd1, 32'h103, 32'h0, 32'h11223380, 1'b1, 5'd4, 32'h0, 0);
        access("lbu_0x103", 4'd2, 32'h103, 32'h0, 32'h11223380, 1'b1, 5'd4, 32'h0, 1);
        access("lh_0x102",  4'd3, 32'h102, 32'h0, 32'h1234F00D, 1'b1, 5'd7, 32'h0, 2);
        access("lhu_0x100", 4'd4, 32'h100, 32'h0, 32'h8001FFFF, 1'b1, 5'd7, 32'h0, 0);
        access("sh_0x202",  4'd7, 32'h202, 32'h0000ABCD, 32'h0, 1'b0, 5'd0, 32'h55, 0);
        access("sb_0x301",  4'd6, 32'h301, 32'h123456A5, 32'h0, 1'b0, 5'd0, 32'h66, 1);
        access("sw_0x400",  4'd8, 32'h400, 32'hCAFEF00D, 32'h0, 1'b0, 5'd0, 32'h77, 0);
    endtask

    task automatic test_misaligned();
        access("lw_0x101_mis", 4'd5, 32'h101, 32'h0, 32'h0, 1'b1, 5'd9, 32'h1, 0);
        access("lh_0x1f3_mis", 4'd3, 32'h1F3, 32'h0, 32'h0, 1'b1, 5'd9, 32'h1, 0);
        access("sw_0x102_mis", 4'd8, 32'h102, 32'h0, 32'h0, 1'b0, 5'd9, 32'h1, 0);
    endtask

    task automatic test_none();
        access("op_none", 4'd0,  32'h103, 32'h0, 32'h0, 1'b1, 5'd17, 32'hA5A5A5A5, 0);
        access("op_12",   4'd12, 32'h101, 32'h0, 32'h0, 1'b0, 5'd18, 32'h5A5A5A5A, 0);
    endtask

    task automatic test_timeout();
        access("lw_timeout",  4'd5, 32'h500, 32'h0, 32'h12345678, 1'b1, 5'd5, 32'h9, -1);
        access("sw_timeout",  4'd8, 32'h504, 32'h87654321, 32'h0, 1'b0, 5'd0, 32'h9, -1);
        access("lw_last_ack", 4'd5, 32'h508, 32'h0, 32'h0BADCAFE, 1'b1, 5'd6, 32'h9, TIMEOUT - 1);
    endtask

    task automatic test_reset_in_bus();
        logic [31:0] wd;
        mem_access_operation       = 4'd5;
        mem_access_address         = 32'h600;
        mem_register_write_enable  = 1'b1;
        mem_register_write_address = 5'd11;
        mem_register_write_data    = 32'h0;
        @(posedge clock); #1;
        reset = 1'b1;
        drive_none();
        wd = mem_register_write_data;
        @(negedge clock);
        n_tests++;
        if (bus_request !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_bus_pre: got req=%b want 1", bus_request);
        end
        @(posedge clock); #1;
        reset           = 1'b0;
        bus_acknowledge = 1'b1;
        bus_read_data   = 32'hFFFF0000;
        @(negedge clock);
        n_tests++;
        if ({bus_request, stall_request, bus_address, wb_register_write_data} !== {2'b00, 32'h0, wd}) begin
            n_fail++;
            $display("FAIL rst_bus_edge: got req=%b stall=%b addr=%h wd=%h want 0 0 0 %h",
                     bus_request, stall_request, bus_address, wb_register_write_data, wd);
        end
        @(posedge clock); #1;
        bus_acknowledge = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({bus_request, stall_request, bus_error, wb_register_write_data} !== {3'b000, wd}) begin
            n_fail++;
            $display("FAIL rst_bus_ack_ignored: got req=%b stall=%b berr=%b wd=%h want 000 wd=%h",
                     bus_request, stall_request, bus_error, wb_register_write_data, wd);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        access("b2b_lw", 4'd5, 32'h700, 32'h0, 32'h01020304, 1'b1, 5'd1, 32'h0, 0);
        access("b2b_sw", 4'd8, 32'h704, 32'hA1B2C3D4, 32'h0, 1'b0, 5'd0, 32'h0, 0);
        access("b2b_lb", 4'd1, 32'h702, 32'h0, 32'h00008000, 1'b1, 5'd2, 32'h0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 80; it++) begin
            logic [3:0]  op    = 4'($urandom_range(0, 15));
            logic [31:0] addr  = $urandom;
            int          d     = int'($urandom_range(0, 4));
            logic        we    = op_load(op) ? 1'($urandom) : 1'b0;
            if (op >= 4'd9 || op == 4'd0) we = 1'($urandom);
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
            access($sformatf("rand%0d_op%0d", it, op), op, addr, $urandom, $urandom, we,
                   5'($urandom), $urandom, (d == 4) ? -1 : d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_misaligned();
        test_none();
        test_timeout();
        test_reset_in_bus();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
